// File: rtl/regfile_wb_scheduler_if.sv
// regfile_wb_scheduler_if: writeback request, reservation, hazard and register file write port bundle
interface regfile_wb_scheduler_if #(
  parameter int N_REQ = 2,
  parameter int XLEN  = 32,
  parameter int AW    = 5
);
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*AW-1:0]   req_rd;
  logic [N_REQ*XLEN-1:0] req_data;
  logic [N_REQ-1:0]      req_ready;
  logic                  rsv_valid;
  logic [AW-1:0]         rsv_rd;
  logic                  rsv_ready;
  logic [AW-1:0]         rs1;
  logic [AW-1:0]         rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic [AW-1:0]         A3;
  logic [XLEN-1:0]       WD3;
  logic                  WE3;
  logic [31:0]           busy_mask;
  logic                  sb_err;
  modport master (
    output req_valid, req_rd, req_data, rsv_valid, rsv_rd, rs1, rs2,
    input  req_ready, rsv_ready, rs1_busy, rs2_busy, A3, WD3, WE3, busy_mask, sb_err
  );
  modport slave (
    input  req_valid, req_rd, req_data, rsv_valid, rsv_rd, rs1, rs2,
    output req_ready, rsv_ready, rs1_busy, rs2_busy, A3, WD3, WE3, busy_mask, sb_err
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: round-robin writeback arbiter driving a registered register file write port, plus destination scoreboard
module regfile_wb_scheduler #(
  parameter int N_REQ = 2,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input logic clk,
  input logic rst,
  regfile_wb_scheduler_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [PW-1:0]    rr, gsel, idx, rr_nxt;
  logic             found;
  logic [N_REQ-1:0] gnt;
  logic [AW-1:0]    wrd, a3;
  logic [XLEN-1:0]  wdat, wd3;
  logic [31:0]      busy, clr, set, busy_nxt;
  logic             rsv_ok, we3, sb_err, wr_nz;
  // first valid requester at or after rr wins; depends only on req_valid
  always_comb begin
    gnt   = '0;
    gsel  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((32'(rr) + 32'(k)) % 32'(N_REQ));
      if (!found && bus.req_valid[idx]) begin
        found    = 1'b1;
        gsel     = idx;
        gnt[idx] = 1'b1;
      end
    end
  end
  assign wrd      = bus.req_rd[gsel*AW +: AW];
  assign wdat     = bus.req_data[gsel*XLEN +: XLEN];
  assign wr_nz    = found && (wrd != '0);
  assign rr_nxt   = (gsel == PW'(N_REQ - 1)) ? '0 : gsel + 1'b1;
  assign rsv_ok   = (bus.rsv_rd == '0) | ~busy[bus.rsv_rd];
  assign clr      = wr_nz ? (32'(1) << wrd) : '0;
  assign set      = (bus.rsv_valid && rsv_ok) ? (32'(1) << bus.rsv_rd) : '0;
  assign busy_nxt = ((busy & ~clr) | set) & ~32'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr     <= '0;
      a3     <= '0;
      wd3    <= '0;
      we3    <= 1'b0;
      busy   <= '0;
      sb_err <= 1'b0;
    end else begin
      we3  <= wr_nz;
      busy <= busy_nxt;
      if (found) begin
        a3  <= wrd;
        wd3 <= wdat;
        rr  <= rr_nxt;
      end
      if (wr_nz && !busy[wrd]) sb_err <= 1'b1;
    end
  end
  assign bus.req_ready = gnt;
  assign bus.rsv_ready = rsv_ok;
  assign bus.rs1_busy  = (bus.rs1 != '0) & busy[bus.rs1];
  assign bus.rs2_busy  = (bus.rs2 != '0) & busy[bus.rs2];
  assign bus.A3        = a3;
  assign bus.WD3       = wd3;
  assign bus.WE3       = we3;
  assign bus.busy_mask = busy;
  assign bus.sb_err    = sb_err;
endmodule
